// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : shared ALU opcodes and alu_ctrl state encoding
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_MUL = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_STROBE = 2'b10,
    ST_RESP   = 2'b11
  } ctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_ctrl.sv
// ============================================================================
// alu_ctrl : request/response sequencer for the 16-bit ALU plus Z/N/V flags
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module alu_ctrl
  import cpu_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_op,
  input  logic [N-1:0] req_a,
  input  logic [N-1:0] req_b,
  input  logic         req_setflags,
  output logic [2:0]   alu_control,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic         alu_enable,
  input  logic [N-1:0] alu_dout,
  input  logic         alu_overflow,
  input  logic         alu_zero,
  input  logic         alu_negative,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_data,
  output logic         rsp_v,
  output logic         rsp_z,
  output logic         rsp_n,
  output logic         flag_v,
  output logic         flag_z,
  output logic         flag_n,
  output logic         busy
);

  ctrl_state_t  r_state;
  ctrl_state_t  w_state_nxt;
  logic         w_accept;
  logic         w_capture;

  logic [2:0]   r_alu_control;
  logic [N-1:0] r_alu_a;
  logic [N-1:0] r_alu_b;
  logic         r_setflags;
  logic         r_alu_enable;
  logic [N-1:0] r_rsp_data;
  logic         r_rsp_v;
  logic         r_rsp_z;
  logic         r_rsp_n;
  logic         r_flag_v;
  logic         r_flag_z;
  logic         r_flag_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SETUP;
        end
      end
      ST_SETUP:  w_state_nxt = ST_STROBE;
      ST_STROBE: begin
        w_capture   = 1'b1;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operands are held from acceptance until the next acceptance so the ALU
  // sees stable inputs for the whole SETUP/STROBE window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_control <= 3'b000;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_setflags    <= 1'b0;
      r_alu_enable  <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_v       <= 1'b0;
      r_rsp_z       <= 1'b0;
      r_rsp_n       <= 1'b0;
      r_flag_v      <= 1'b0;
      r_flag_z      <= 1'b0;
      r_flag_n      <= 1'b0;
    end else begin
      r_alu_enable <= (w_state_nxt == ST_STROBE);
      if (w_accept) begin
        r_alu_control <= req_op;
        r_alu_a       <= req_a;
        r_alu_b       <= req_b;
        r_setflags    <= req_setflags;
      end
      if (w_capture) begin
        r_rsp_data <= alu_dout;
        r_rsp_v    <= alu_overflow;
        r_rsp_z    <= alu_zero;
        r_rsp_n    <= alu_negative;
        if (r_setflags) begin
          r_flag_v <= alu_overflow;
          r_flag_z <= alu_zero;
          r_flag_n <= alu_negative;
        end
      end
    end
  end

  assign req_ready   = (r_state == ST_IDLE);
  assign rsp_valid   = (r_state == ST_RESP);
  assign busy        = (r_state != ST_IDLE);
  assign alu_control = r_alu_control;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_enable  = r_alu_enable;
  assign rsp_data    = r_rsp_data;
  assign rsp_v       = r_rsp_v;
  assign rsp_z       = r_rsp_z;
  assign rsp_n       = r_rsp_n;
  assign flag_v      = r_flag_v;
  assign flag_z      = r_flag_z;
  assign flag_n      = r_flag_n;

endmodule

`default_nettype wire

// File: tb/tb_alu_ctrl.sv
// ============================================================================
// tb_alu_ctrl : self-checking bench for alu_ctrl with an attached ALU model
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_alu_ctrl;

  localparam int N = 16;

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_op;
  logic [N-1:0] req_a;
  logic [N-1:0] req_b;
  logic         req_setflags;
  logic [2:0]   alu_control;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic         alu_enable;
  logic [N-1:0] alu_dout;
  logic         alu_overflow;
  logic         alu_zero;
  logic         alu_negative;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_data;
  logic         rsp_v;
  logic         rsp_z;
  logic         rsp_n;
  logic         flag_v;
  logic         flag_z;
  logic         flag_n;
  logic         busy;

  alu_ctrl #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_setflags(req_setflags),
    .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b),
    .alu_enable(alu_enable), .alu_dout(alu_dout),
    .alu_overflow(alu_overflow), .alu_zero(alu_zero), .alu_negative(alu_negative),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_v(rsp_v), .rsp_z(rsp_z), .rsp_n(rsp_n),
    .flag_v(flag_v), .flag_z(flag_z), .flag_n(flag_n), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic        v;
    logic        z;
    logic        n;
  } res_t;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        sf;
    res_t        exp;
  } vec_t;

  typedef struct {
    res_t r;
    logic sf;
  } pend_t;

  // Reference: plain integer arithmetic on the operands as the ALU defines it.
  function automatic res_t ref_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    res_t r;
    int   sa;
    int   sb;
    int   s;
    sa  = $signed(a);
    sb  = $signed(b);
    r   = '0;
    s   = 0;
    case (op)
      3'd0: begin s = sa + sb; r.d = s[15:0]; r.v = (s > 32767) || (s < -32768); end
      3'd1: begin s = sa - sb; r.d = s[15:0]; r.v = (s > 32767) || (s < -32768); end
      3'd2: r.d = a & b;
      3'd3: r.d = a | b;
      3'd4: r.d = a ^ b;
      default: begin s = (int'(a) % 256) * (int'(b) % 256); r.d = s[15:0]; end
    endcase
    r.z = (r.d == 16'h0000);
    r.n = r.d[15];
    return r;
  endfunction

  int   strobes = 0;
  res_t alu_r;

  // Attached ALU: evaluates on the rising edge of its enable strobe.
  initial begin
    alu_dout     = '0;
    alu_overflow = 1'b0;
    alu_zero     = 1'b0;
    alu_negative = 1'b0;
  end
  always @(posedge alu_enable) begin
    strobes++;
    alu_r        = ref_alu(alu_control, alu_a, alu_b);
    alu_dout     = alu_r.d;
    alu_overflow = alu_r.v;
    alu_zero     = alu_r.z;
    alu_negative = alu_r.n;
  end

  int   nvec = 0;
  int   nerr = 0;
  logic mf_v = 1'b0;
  logic mf_z = 1'b0;
  logic mf_n = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("idle_wait", req_ready, 1);
  endtask

  // One operation from acceptance to IDLE, with `hold` cycles of backpressure.
  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic sf, input int hold, input res_t e);
    int s0;
    wait_idle();
    req_valid    = 1'b1;
    req_op       = op;
    req_a        = a;
    req_b        = b;
    req_setflags = sf;
    rsp_ready    = (hold == 0);
    s0           = strobes;
    @(negedge clk);
    req_valid    = 1'b0;
    req_op       = 3'($urandom);
    req_a        = 16'($urandom);
    req_b        = 16'($urandom);
    req_setflags = 1'($urandom);
    chk("setup_enable", alu_enable, 0);
    chk("setup_busy", busy, 1);
    chk("setup_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    chk("strobe_enable", alu_enable, 1);
    chk("strobe_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    if (sf) begin
      mf_v = e.v;
      mf_z = e.z;
      mf_n = e.n;
    end
    chk("rsp_valid_lat2", rsp_valid, 1);
    chk("rsp_data", rsp_data, e.d);
    chk("rsp_vzn", {rsp_v, rsp_z, rsp_n}, {e.v, e.z, e.n});
    chk("flag_vzn", {flag_v, flag_z, flag_n}, {mf_v, mf_z, mf_n});
    chk("resp_enable", alu_enable, 0);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_a     = 16'($urandom);
      @(negedge clk);
      chk("bp_rsp_data", rsp_data, e.d);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_rsp_valid", rsp_valid, 1);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("back_idle", req_ready, 1);
    chk("idle_rsp_valid", rsp_valid, 0);
    chk("idle_rsp_hold", rsp_data, e.d);
    chk("one_strobe", strobes - s0, 1);
    rsp_ready = 1'b0;
  endtask

  vec_t  tbl[8];
  pend_t q[$];
  int    acc[$];
  int    cyc;
  int    s0;
  pend_t p;

  initial begin
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_op       = '0;
    req_a        = '0;
    req_b        = '0;
    req_setflags = 1'b0;
    rsp_ready    = 1'b0;

    tbl[0] = '{3'b000, 16'h7FFF, 16'h0001, 1'b1, '{16'h8000, 1'b1, 1'b0, 1'b1}};
    tbl[1] = '{3'b001, 16'h0005, 16'h0005, 1'b0, '{16'h0000, 1'b0, 1'b1, 1'b0}};
    tbl[2] = '{3'b101, 16'h0003, 16'h0004, 1'b1, '{16'h000C, 1'b0, 1'b0, 1'b0}};
    tbl[3] = '{3'b100, 16'hFFFF, 16'h00FF, 1'b1, '{16'hFF00, 1'b0, 1'b0, 1'b1}};
    tbl[4] = '{3'b010, 16'hF0F0, 16'h0FF0, 1'b0, '{16'h00F0, 1'b0, 1'b0, 1'b0}};
    tbl[5] = '{3'b011, 16'h8000, 16'h0001, 1'b1, '{16'h8001, 1'b0, 1'b0, 1'b1}};
    tbl[6] = '{3'b001, 16'h8000, 16'h0001, 1'b1, '{16'h7FFF, 1'b1, 1'b0, 1'b0}};
    tbl[7] = '{3'b111, 16'h0102, 16'h0003, 1'b0, '{16'h0006, 1'b0, 1'b0, 1'b0}};

    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_enable", alu_enable, 0);
    chk("rst_alu_regs", {13'd0, alu_control, alu_a}, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_rsp", {rsp_valid, rsp_v, rsp_z, rsp_n, rsp_data}, 0);
    chk("rst_flags", {flag_v, flag_z, flag_n}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sf, (i == 1) ? 10 : 0, tbl[i].exp);
    chk("sub_nosf_flags_kept", {flag_v, flag_z, flag_n}, {mf_v, mf_z, mf_n});

    for (int i = 0; i < 30; i++) begin
      logic [2:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      op = 3'($urandom_range(0, 7));
      a  = 16'($urandom);
      b  = 16'($urandom);
      run_op(op, a, b, 1'($urandom), $urandom_range(0, 2), ref_alu(op, a, b));
    end

    // Reset asserted in the middle of STROBE drops the operation.
    run_op(3'b000, 16'h7FFF, 16'h0001, 1'b1, 0, ref_alu(3'b000, 16'h7FFF, 16'h0001));
    wait_idle();
    req_valid    = 1'b1;
    req_op       = 3'b000;
    req_a        = 16'h0001;
    req_b        = 16'h0001;
    req_setflags = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_enable", alu_enable, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_enable", alu_enable, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_flags", {flag_v, flag_z, flag_n}, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rsp_data", rsp_data, 0);
    mf_v = 1'b0;
    mf_z = 1'b0;
    mf_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(3'b000, 16'h0001, 16'h0001, 1'b0, 0, '{16'h0002, 1'b0, 1'b0, 1'b0});

    // Back-to-back stream with writeback always ready.
    rsp_ready    = 1'b1;
    req_valid    = 1'b1;
    req_op       = 3'($urandom);
    req_a        = 16'($urandom);
    req_b        = 16'($urandom);
    req_setflags = 1'($urandom);
    s0           = strobes;
    for (cyc = 0; cyc < 36; cyc++) begin
      if (cyc == 28) req_valid = 1'b0;
      if (rsp_valid) begin
        if (q.size() == 0) begin
          chk("b2b_unexpected_rsp", rsp_valid, 0);
        end else begin
          p = q.pop_front();
          if (p.sf) begin
            mf_v = p.r.v;
            mf_z = p.r.z;
            mf_n = p.r.n;
          end
          chk("b2b_rsp_data", rsp_data, p.r.d);
          chk("b2b_rsp_vzn", {rsp_v, rsp_z, rsp_n}, {p.r.v, p.r.z, p.r.n});
          chk("b2b_flags", {flag_v, flag_z, flag_n}, {mf_v, mf_z, mf_n});
        end
      end
      if (req_valid && req_ready) begin
        q.push_back('{ref_alu(req_op, req_a, req_b), req_setflags});
        acc.push_back(cyc);
      end else begin
        req_op       = 3'($urandom);
        req_a        = 16'($urandom);
        req_b        = 16'($urandom);
        req_setflags = 1'($urandom);
      end
      @(negedge clk);
    end
    chk("b2b_count", acc.size(), 7);
    for (int i = 1; i < acc.size(); i++)
      chk("b2b_spacing", acc[i] - acc[i-1], 4);
    chk("b2b_drained", q.size(), 0);
    chk("b2b_strobes", strobes - s0, acc.size());

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_ctrl.md
# alu_ctrl

Sequencing front end for the 16-bit ALU: accepts one operation per request over a valid/ready handshake, drives the ALU's `control`/`a`/`b` inputs and its edge-triggered `enable` strobe, then captures `dOut` and flags. It returns the result over a second valid/ready handshake. It also maintains the architectural Z/N/V condition-flag register consumed by branch logic. It sits between decode and writeback in the execute stage, instantiated beside `alu`.

## Interface
- `N`, 16, datapath width; must match the attached ALU.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  decode presents an operation.
- `req_ready`  out  1  high only in IDLE; transfer when `req_valid & req_ready`.
- `req_op`  in  3  ALU opcode: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101–111 multiply.
- `req_a`, `req_b`  in  N  signed operands.
- `req_setflags`  in  1  update the flag register from this operation's result.
- `alu_control`  out  3  registered opcode to the ALU.
- `alu_a`, `alu_b`  out  N  registered operands to the ALU.
- `alu_enable`  out  1  registered one-cycle strobe; the ALU evaluates on its rising edge.
- `alu_dout`  in  N  ALU result.
- `alu_overflow`, `alu_zero`, `alu_negative`  in  1 each  ALU flags.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  writeback accepts; transfer when `rsp_valid & rsp_ready`.
- `rsp_data`  out  N  captured result.
- `rsp_v`, `rsp_z`, `rsp_n`  out  1 each  flags of this operation.
- `flag_v`, `flag_z`, `flag_n`  out  1 each  architectural flag register.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, SETUP, STROBE, RESP.
- IDLE: `req_ready`=1. On request transfer, latch op, a, b and setflags into the `alu_*` and setflags registers, then go to SETUP.
- SETUP: operands are stable and `alu_enable`=0. Next state is STROBE, with `alu_enable` registered to 1.
- STROBE: `alu_enable`=1 for exactly this cycle. At the exiting edge:
  - capture `alu_dout` and the three ALU flags into `rsp_*`;
  - if setflags, copy them into `flag_*`;
  - clear `alu_enable` and go to RESP.
- RESP: `rsp_valid`=1. On `rsp_ready` go to IDLE. `rsp_*` hold until the next capture.
- Every accepted operation produces exactly one `alu_enable` rising edge; `alu_enable` is 0 in IDLE, SETUP and RESP.
- No arithmetic is performed here; results and flags are passed through unmodified.
- ALU overflow semantics apply: V is meaningful only for add/sub and is 0 otherwise. Multiply uses the low operand bits, per the ALU.
- Opcodes 101–111 are forwarded unchanged; no error is raised.
- Reset, async at any state including mid-STROBE, clears all of the following immediately:
  - state to IDLE;
  - `alu_enable`, `alu_control`, `alu_a`, `alu_b` to 0;
  - `rsp_valid`, `rsp_data`, `rsp_*` flags to 0;
  - `flag_*` to 0 and `busy` to 0.
- An operation in flight at reset is dropped.

## Timing
- Acceptance edge E0, then SETUP, then STROBE.
- `alu_enable` is high between E1 and E2.
- Result is captured at E2; `rsp_valid` is high from E2, a latency of 2 cycles.
- With `rsp_ready` held high, RESP lasts one cycle and IDLE is re-entered at E3. Peak throughput is one operation per 4 cycles.
- Backpressure: `rsp_ready` low holds RESP indefinitely. `rsp_*` stay stable, `req_ready` stays 0, and no further strobe occurs.
- `req_*` are sampled only at the acceptance edge; changes at other times are ignored.
- `flag_*` change only at the STROBE exit edge of an operation with setflags=1.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode localparams `ALU_ADD`=3'b000, `ALU_SUB`, `ALU_AND`, `ALU_OR`, `ALU_XOR`, `ALU_MUL`=3'b101;
  - the 2-bit state encoding IDLE=00, SETUP=01, STROBE=10, RESP=11.
- Single module with no sub-modules; the ALU instance lives in the parent execute stage.

## Test plan
- Add 0x7FFF + 0x0001, setflags=1 → `rsp_data`=0x8000, V=1, N=1, Z=0; `flag_*` match; `rsp_valid` 2 cycles after acceptance.
- Sub 0x0005 − 0x0005, setflags=0, prior flags V=1 N=1 Z=0 → `rsp_data`=0x0000, `rsp_z`=1; `flag_*` unchanged.
- Mul op 3'b101, a=0x0003, b=0x0004 → `rsp_data`=0x000C, `rsp_v`=0. Xor 0xFFFF^0x00FF → 0xFF00, N=1.
- Hold `rsp_ready`=0 for 10 cycles with `req_valid` high → `rsp_data` stable, `req_ready`=0, exactly one `alu_enable` pulse counted.
- Assert `rst_n`=0 during STROBE → in the same cycle `alu_enable`=0, `rsp_valid`=0, `flag_*`=0, `busy`=0. After release, a new add 0x0001+0x0001 returns 0x0002.
- Back-to-back requests with `rsp_ready` always high → acceptances spaced exactly 4 cycles apart; one strobe per operation.
